hazard_ctl_rv32: RTL

Scoreboard-based issue controller for the RV32I decode stage. It tracks outstanding register writes between issue (ID→EX) and writeback. It decides each cycle whether the instruction in decode may issue, or whether IF/ID must stall. It also sequences a fence/drain request that empties the pipeline before signalling completion.

---
 rtl/hazard_ctl_rv32_pkg.sv | 22 ++
 rtl/hazard_ctl_rv32_sb_counter.sv | 49 ++++
 rtl/hazard_ctl_rv32.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hazard_ctl_rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctl_rv32_pkg
// Description : Shared decode-stage definitions for the RV32I issue controller.
//               Holds the fence FSM state encoding and register constants.
// Revision    : 1.0  initial release
// ============================================================================
package hazard_ctl_rv32_pkg;

  // Fence/drain sequencer states
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } fence_st_e;

  // Architectural zero register: never tracked by the scoreboard
  localparam logic [4:0] REG_X0   = 5'd0;
  localparam int         NUM_REGS = 32;

endpackage : hazard_ctl_rv32_pkg
`default_nettype wire

// File: rtl/hazard_ctl_rv32_sb_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter_rv32
// Description : Pending-write counter for one architectural register.
//               Saturates at all-ones, never wraps below zero, and flags a
//               retire that arrives while the count is already zero.
// Revision    : 1.0  initial release
// ============================================================================
module sb_counter_rv32 #(
  parameter int CNT_W = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o,
  output logic             underflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a retire against an empty counter is dropped, the issue still counts
  always_comb begin
    cnt_d = cnt_q;
    case ({inc_i, dec_i})
      2'b10:   if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      2'b01:   if (cnt_q != '0)      cnt_d = cnt_q - CNT_ONE;
      2'b11:   if (cnt_q == '0)      cnt_d = cnt_q + CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Count register
  always_ff @(posedge iCLK) begin
    if (iRST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o       = cnt_q;
  assign busy_o      = (cnt_q != '0);
  assign underflow_o = dec_i && (cnt_q == '0);

endmodule : sb_counter_rv32
`default_nettype wire

// File: rtl/hazard_ctl_rv32.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctl_rv32
// Description : Scoreboard-based issue controller for the RV32I decode stage.
//               Tracks outstanding register writes, resolves RAW / WAW-
//               saturation / in-flight-limit stalls and sequences fence drains.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_ctl_rv32
  import hazard_ctl_rv32_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 2,
  parameter int WB_BYPASS    = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iIDValid,
  input  logic [4:0]  iRs1Addr,
  input  logic        iRs1Used,
  input  logic [4:0]  iRs2Addr,
  input  logic        iRs2Used,
  input  logic [4:0]  iRdAddr,
  input  logic        iRdWrite,
  input  logic        iEXReady,
  input  logic        iFlush,
  input  logic        iFence,
  input  logic        iWBValid,
  input  logic        iWBWrite,
  input  logic [4:0]  iWBAddr,
  output logic        oIssue,
  output logic        oStallIF,
  output logic        oStallID,
  output logic [31:0] oBusyMask,
  output logic [2:0]  oInflight,
  output logic        oFenceDone,
  output logic        oSbError
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fence_st_e        state_q, state_d;
  logic [2:0]       inflight_q, inflight_d, inflight_eff;
  logic             fence_done_q;
  logic             sb_err_q, sb_err_d;

  logic [CNT_W-1:0] cnt_w [NUM_REGS];
  logic [31:0]      busy_w, underflow_w, inc_w, dec_w;
  logic             wb_wr_w, retire_ok, slot_ok, hazard_w, issue_w;
  logic             rs1_haz, rs2_haz, waw_haz;

  assign wb_wr_w = iWBValid && iWBWrite && (iWBAddr != REG_X0);

  // x0 has no counter; all of its scoreboard views are constant zero
  assign cnt_w[0]       = '0;
  assign busy_w[0]      = 1'b0;
  assign underflow_w[0] = 1'b0;
  assign inc_w[0]       = 1'b0;
  assign dec_w[0]       = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    assign inc_w[r] = issue_w && iRdWrite && (iRdAddr == 5'(r));
    assign dec_w[r] = wb_wr_w && (iWBAddr == 5'(r));
    sb_counter_rv32 #(.CNT_W(CNT_W)) u_cnt (
      .iCLK        (iCLK),
      .iRST        (iRST),
      .inc_i       (inc_w[r]),
      .dec_i       (dec_w[r]),
      .cnt_o       (cnt_w[r]),
      .busy_o      (busy_w[r]),
      .underflow_o (underflow_w[r])
    );
  end

  // Hazard detection: a source retiring its last pending write this cycle is free
  always_comb begin
    rs1_haz = iRs1Used && (iRs1Addr != REG_X0) && busy_w[iRs1Addr] &&
              !((WB_BYPASS != 0) && wb_wr_w && (iWBAddr == iRs1Addr) &&
                (cnt_w[iRs1Addr] == CNT_ONE));
    rs2_haz = iRs2Used && (iRs2Addr != REG_X0) && busy_w[iRs2Addr] &&
              !((WB_BYPASS != 0) && wb_wr_w && (iWBAddr == iRs2Addr) &&
                (cnt_w[iRs2Addr] == CNT_ONE));
    waw_haz = iRdWrite && (iRdAddr != REG_X0) && (cnt_w[iRdAddr] == CNT_MAX);
    hazard_w = rs1_haz || rs2_haz || waw_haz;
  end

  // Issue decision and stalls; the in-flight limit already sees this cycle's retire
  always_comb begin
    retire_ok    = iWBValid && (inflight_q != '0);
    inflight_eff = inflight_q - {2'b00, retire_ok};
    slot_ok      = (inflight_eff < 3'(MAX_INFLIGHT));
    issue_w      = (state_q == ST_RUN) && !iFence && iIDValid && !iFlush &&
                   iEXReady && !hazard_w && slot_ok;
    inflight_d   = inflight_eff + {2'b00, issue_w};
    sb_err_d     = sb_err_q || (iWBValid && (inflight_q == '0)) || (|underflow_w);
    oIssue       = issue_w;
    if (state_q == ST_DRAIN) oStallID = iIDValid;
    else                     oStallID = iIDValid && !iFlush && !issue_w;
    oStallIF     = oStallID;
  end

  // Fence sequencer next state: drain until nothing remains in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (iFence) state_d = ST_DRAIN;
      ST_DRAIN: if (inflight_d == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Controller state registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= ST_RUN;
      inflight_q   <= '0;
      fence_done_q <= 1'b0;
      sb_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      fence_done_q <= (state_d == ST_DONE);
      sb_err_q     <= sb_err_d;
    end
  end

  assign oBusyMask  = busy_w;
  assign oInflight  = inflight_q;
  assign oFenceDone = fence_done_q;
  assign oSbError   = sb_err_q;

endmodule : hazard_ctl_rv32
`default_nettype wire
